// File: rtl/stack_pointer_unit.sv
// Main and return stack pointers with depth tracking, full/empty status and sticky overflow/underflow faults.
// Optional STACK_HWM_EN adds per-stack high-water-mark outputs ms_hwm and rs_hwm.
module stack_pointer_unit #(
    parameter logic [15:0] MS_BASE  = 16'h7FFE,
    parameter logic [15:0] RS_BASE  = 16'h6FFE,
    parameter logic [15:0] STEP     = 16'd2,
    parameter int unsigned MS_DEPTH = 512,
    parameter int unsigned RS_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MSPop,
    input  logic        MSPWrite,
    input  logic        MSPRegReset,
    input  logic        RSPop,
    input  logic        RSPWrite,
    input  logic        RSPRegReset,
    output logic [15:0] msp,
    output logic [15:0] msp_second,
    output logic [15:0] rsp,
    output logic [15:0] ms_depth,
    output logic [15:0] rs_depth,
    output logic        ms_empty,
    output logic        rs_empty,
    output logic        ms_full,
    output logic        rs_full,
    output logic        ms_overflow,
    output logic        ms_underflow,
    output logic        rs_overflow,
    output logic        rs_underflow,
`ifdef STACK_HWM_EN
    output logic [15:0] ms_hwm,
    output logic [15:0] rs_hwm,
`endif
    output logic        stack_fault
);

    localparam logic [15:0] MS_MAX = 16'(MS_DEPTH);
    localparam logic [15:0] RS_MAX = 16'(RS_DEPTH);

    logic [15:0] r_msp, r_rsp, r_ms_depth, r_rs_depth;
    logic        r_ms_ovf, r_ms_unf, r_rs_ovf, r_rs_unf;

    logic [15:0] w_msp_nxt, w_rsp_nxt, w_ms_depth_nxt, w_rs_depth_nxt;
    logic        w_ms_ovf_nxt, w_ms_unf_nxt, w_rs_ovf_nxt, w_rs_unf_nxt;

    // Stacks grow downward: a push lowers the pointer, a pop raises it.
    always_comb begin
        w_msp_nxt      = r_msp;
        w_ms_depth_nxt = r_ms_depth;
        w_ms_ovf_nxt   = r_ms_ovf;
        w_ms_unf_nxt   = r_ms_unf;
        if (MSPRegReset) begin
            w_msp_nxt      = MS_BASE;
            w_ms_depth_nxt = '0;
            w_ms_ovf_nxt   = 1'b0;
            w_ms_unf_nxt   = 1'b0;
        end else if (MSPWrite) begin
            if (MSPop) begin
                if (r_ms_depth != '0) begin
                    w_msp_nxt      = r_msp + STEP;
                    w_ms_depth_nxt = r_ms_depth - 16'd1;
                end else begin
                    w_ms_unf_nxt = 1'b1;
                end
            end else begin
                if (r_ms_depth < MS_MAX) begin
                    w_msp_nxt      = r_msp - STEP;
                    w_ms_depth_nxt = r_ms_depth + 16'd1;
                end else begin
                    w_ms_ovf_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rsp_nxt      = r_rsp;
        w_rs_depth_nxt = r_rs_depth;
        w_rs_ovf_nxt   = r_rs_ovf;
        w_rs_unf_nxt   = r_rs_unf;
        if (RSPRegReset) begin
            w_rsp_nxt      = RS_BASE;
            w_rs_depth_nxt = '0;
            w_rs_ovf_nxt   = 1'b0;
            w_rs_unf_nxt   = 1'b0;
        end else if (RSPWrite) begin
            if (RSPop) begin
                if (r_rs_depth != '0) begin
                    w_rsp_nxt      = r_rsp + STEP;
                    w_rs_depth_nxt = r_rs_depth - 16'd1;
                end else begin
                    w_rs_unf_nxt = 1'b1;
                end
            end else begin
                if (r_rs_depth < RS_MAX) begin
                    w_rsp_nxt      = r_rsp - STEP;
                    w_rs_depth_nxt = r_rs_depth + 16'd1;
                end else begin
                    w_rs_ovf_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msp      <= MS_BASE;
            r_rsp      <= RS_BASE;
            r_ms_depth <= '0;
            r_rs_depth <= '0;
            r_ms_ovf   <= 1'b0;
            r_ms_unf   <= 1'b0;
            r_rs_ovf   <= 1'b0;
            r_rs_unf   <= 1'b0;
        end else begin
            r_msp      <= w_msp_nxt;
            r_rsp      <= w_rsp_nxt;
            r_ms_depth <= w_ms_depth_nxt;
            r_rs_depth <= w_rs_depth_nxt;
            r_ms_ovf   <= w_ms_ovf_nxt;
            r_ms_unf   <= w_ms_unf_nxt;
            r_rs_ovf   <= w_rs_ovf_nxt;
            r_rs_unf   <= w_rs_unf_nxt;
        end
    end

`ifdef STACK_HWM_EN
    logic [15:0] r_ms_hwm, r_rs_hwm;

    // Compared against the next depth so the mark moves on the same edge as depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ms_hwm <= '0;
            r_rs_hwm <= '0;
        end else begin
            if (MSPRegReset)
                r_ms_hwm <= '0;
            else if (w_ms_depth_nxt > r_ms_hwm)
                r_ms_hwm <= w_ms_depth_nxt;
            if (RSPRegReset)
                r_rs_hwm <= '0;
            else if (w_rs_depth_nxt > r_rs_hwm)
                r_rs_hwm <= w_rs_depth_nxt;
        end
    end

    assign ms_hwm = r_ms_hwm;
    assign rs_hwm = r_rs_hwm;
`endif

    assign msp          = r_msp;
    assign msp_second   = r_msp + STEP;
    assign rsp          = r_rsp;
    assign ms_depth     = r_ms_depth;
    assign rs_depth     = r_rs_depth;
    assign ms_empty     = (r_ms_depth == '0);
    assign rs_empty     = (r_rs_depth == '0);
    assign ms_full      = (r_ms_depth == MS_MAX);
    assign rs_full      = (r_rs_depth == RS_MAX);
    assign ms_overflow  = r_ms_ovf;
    assign ms_underflow = r_ms_unf;
    assign rs_overflow  = r_rs_ovf;
    assign rs_underflow = r_rs_unf;
    assign stack_fault  = r_ms_ovf | r_ms_unf | r_rs_ovf | r_rs_unf;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit: directed scenarios plus randomized traffic against a depth-count model.
module tb_stack_pointer_unit;

    localparam int MSD = 8;
    localparam int RSD = 4;
    localparam int MS_BASE_I = 'h7FFE;
    localparam int RS_BASE_I = 'h6FFE;

    logic        clk, rst;
    logic        MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset;
    logic [15:0] msp, msp_second, rsp, ms_depth, rs_depth;
    logic        ms_empty, rs_empty, ms_full, rs_full;
    logic        ms_overflow, ms_underflow, rs_overflow, rs_underflow, stack_fault;
`ifdef STACK_HWM_EN
    logic [15:0] ms_hwm, rs_hwm;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: entry counts, sticky flags and high-water marks.
    int m_md, m_rd, m_mh, m_rh;
    bit m_mo, m_mu, m_ro, m_ru;

    stack_pointer_unit #(
        .MS_BASE(16'h7FFE), .RS_BASE(16'h6FFE), .STEP(16'd2),
        .MS_DEPTH(MSD), .RS_DEPTH(RSD)
    ) dut (
        .clk(clk), .rst(rst),
        .MSPop(MSPop), .MSPWrite(MSPWrite), .MSPRegReset(MSPRegReset),
        .RSPop(RSPop), .RSPWrite(RSPWrite), .RSPRegReset(RSPRegReset),
        .msp(msp), .msp_second(msp_second), .rsp(rsp),
        .ms_depth(ms_depth), .rs_depth(rs_depth),
        .ms_empty(ms_empty), .rs_empty(rs_empty),
        .ms_full(ms_full), .rs_full(rs_full),
        .ms_overflow(ms_overflow), .ms_underflow(ms_underflow),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow),
`ifdef STACK_HWM_EN
        .ms_hwm(ms_hwm), .rs_hwm(rs_hwm),
`endif
        .stack_fault(stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_md = 0; m_rd = 0; m_mh = 0; m_rh = 0;
        m_mo = 0; m_mu = 0; m_ro = 0; m_ru = 0;
    endtask

    task automatic model_step();
        if (MSPRegReset) begin
            m_md = 0; m_mo = 0; m_mu = 0; m_mh = 0;
        end else if (MSPWrite) begin
            if (MSPop) begin
                if (m_md > 0) m_md--; else m_mu = 1;
            end else begin
                if (m_md < MSD) m_md++; else m_mo = 1;
            end
        end
        if (m_md > m_mh) m_mh = m_md;
        if (RSPRegReset) begin
            m_rd = 0; m_ro = 0; m_ru = 0; m_rh = 0;
        end else if (RSPWrite) begin
            if (RSPop) begin
                if (m_rd > 0) m_rd--; else m_ru = 1;
            end else begin
                if (m_rd < RSD) m_rd++; else m_ro = 1;
            end
        end
        if (m_rd > m_rh) m_rh = m_rd;
    endtask

    task automatic idle_inputs();
        MSPop = 0; MSPWrite = 0; MSPRegReset = 0;
        RSPop = 0; RSPWrite = 0; RSPRegReset = 0;
    endtask

    // Advance one clock edge, update the model, and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        checks++;
        if ({msp, rsp, ms_depth, rs_depth} !== {16'h7FFE, 16'h6FFE, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_ptrs msp=%h rsp=%h msd=%0d rsd=%0d expected 7ffe 6ffe 0 0", msp, rsp, ms_depth, rs_depth);
        end
        @(negedge clk);
        rst = 1'b0;
        MSPWrite = 1; RSPWrite = 1;
        tick();
        tick();
        idle_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({msp, rsp, ms_depth, rs_depth} !== {16'h7FFE, 16'h6FFE, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL async_reset_ptrs msp=%h rsp=%h msd=%0d rsd=%0d expected 7ffe 6ffe 0 0", msp, rsp, ms_depth, rs_depth);
        end
        checks++;
        if ({ms_empty, rs_empty, stack_fault} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset_flags empty/empty/fault=%b expected 110", {ms_empty, rs_empty, stack_fault});
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        MSPWrite = 1; MSPop = 0;
        tick(); tick(); tick();
        checks++;
        if ({msp, ms_depth, msp_second} !== {16'h7FF8, 16'd3, 16'h7FFA}) begin
            errors++;
            $display("FAIL push3 msp=%h depth=%0d second=%h expected 7ff8 3 7ffa", msp, ms_depth, msp_second);
        end
        MSPop = 1;
        tick();
        idle_inputs();
        checks++;
        if ({msp, ms_depth} !== {16'h7FFA, 16'd2}) begin
            errors++;
            $display("FAIL pop1 msp=%h depth=%0d expected 7ffa 2", msp, ms_depth);
        end
        tick();
        checks++;
        if ({msp, ms_depth} !== {16'h7FFA, 16'd2}) begin
            errors++;
            $display("FAIL hold msp=%h depth=%0d expected 7ffa 2", msp, ms_depth);
        end
    endtask

    task automatic test_underflow();
        MSPRegReset = 1;
        tick();
        MSPRegReset = 0; MSPWrite = 1; MSPop = 1;
        tick();
        idle_inputs();
        checks++;
        if ({msp, ms_underflow, stack_fault, ms_depth} !== {16'h7FFE, 1'b1, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL underflow msp=%h unf=%b fault=%b depth=%0d expected 7ffe 1 1 0", msp, ms_underflow, stack_fault, ms_depth);
        end
        tick();
        checks++;
        if (ms_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky unf=%b expected 1", ms_underflow);
        end
        MSPRegReset = 1;
        tick();
        idle_inputs();
        checks++;
        if ({ms_underflow, stack_fault} !== 2'b00) begin
            errors++;
            $display("FAIL underflow_clear unf=%b fault=%b expected 0 0", ms_underflow, stack_fault);
        end
    endtask

    task automatic test_overflow();
        RSPRegReset = 1;
        tick();
        RSPRegReset = 0; RSPWrite = 1; RSPop = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({rsp, rs_full, rs_depth} !== {16'h6FF6, 1'b1, 16'd4}) begin
            errors++;
            $display("FAIL full rsp=%h full=%b depth=%0d expected 6ff6 1 4", rsp, rs_full, rs_depth);
        end
        checks++;
        if (rs_overflow !== 1'b0) begin
            errors++;
            $display("FAIL no_early_ovf ovf=%b expected 0", rs_overflow);
        end
        tick();
        idle_inputs();
        checks++;
        if ({rsp, rs_overflow, stack_fault} !== {16'h6FF6, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overflow rsp=%h ovf=%b fault=%b expected 6ff6 1 1", rsp, rs_overflow, stack_fault);
        end
        checks++;
        if ({ms_overflow, ms_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL ms_isolated ovf/unf=%b expected 00", {ms_overflow, ms_underflow});
        end
    endtask

    task automatic test_simultaneous();
        MSPRegReset = 1; RSPRegReset = 1;
        tick();
        idle_inputs();
        RSPWrite = 1;
        tick();
        MSPWrite = 1; MSPop = 0; RSPWrite = 1; RSPop = 1;
        tick();
        idle_inputs();
        checks++;
        if ({msp, ms_depth, rsp, rs_depth} !== {16'h7FFC, 16'd1, 16'h6FFE, 16'd0}) begin
            errors++;
            $display("FAIL simultaneous msp=%h msd=%0d rsp=%h rsd=%0d expected 7ffc 1 6ffe 0", msp, ms_depth, rsp, rs_depth);
        end
        MSPWrite = 1; MSPRegReset = 1;
        tick();
        idle_inputs();
        checks++;
        if ({msp, ms_depth, ms_empty} !== {16'h7FFE, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL regreset_wins msp=%h depth=%0d empty=%b expected 7ffe 0 1", msp, ms_depth, ms_empty);
        end
    endtask

`ifdef STACK_HWM_EN
    task automatic test_hwm();
        MSPRegReset = 1;
        tick();
        MSPRegReset = 0; MSPWrite = 1; MSPop = 0;
        for (int i = 0; i < 5; i++) tick();
        MSPop = 1;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        checks++;
        if ({ms_hwm, ms_depth} !== {16'd5, 16'd2}) begin
            errors++;
            $display("FAIL hwm hwm=%0d depth=%0d expected 5 2", ms_hwm, ms_depth);
        end
        MSPRegReset = 1;
        tick();
        idle_inputs();
        checks++;
        if (ms_hwm !== 16'd0) begin
            errors++;
            $display("FAIL hwm_clear hwm=%0d expected 0", ms_hwm);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] e_msp, e_rsp;
        for (int n = 0; n < 400; n++) begin
            MSPWrite    = ($urandom_range(0, 3) != 0);
            MSPop       = ($urandom_range(0, 9) < 4);
            MSPRegReset = ($urandom_range(0, 31) == 0);
            RSPWrite    = ($urandom_range(0, 3) != 0);
            RSPop       = ($urandom_range(0, 9) < 4);
            RSPRegReset = ($urandom_range(0, 31) == 0);
            tick();
            e_msp = 16'(MS_BASE_I - 2 * m_md);
            e_rsp = 16'(RS_BASE_I - 2 * m_rd);
            checks++;
            if ({msp, msp_second, rsp, ms_depth, rs_depth} !==
                {e_msp, 16'(e_msp + 16'd2), e_rsp, 16'(m_md), 16'(m_rd)}) begin
                errors++;
                $display("FAIL rand_ptr[%0d] msp=%h sec=%h rsp=%h msd=%0d rsd=%0d expected %h %h %h %0d %0d",
                         n, msp, msp_second, rsp, ms_depth, rs_depth,
                         e_msp, 16'(e_msp + 16'd2), e_rsp, m_md, m_rd);
            end
            checks++;
            if ({ms_empty, rs_empty, ms_full, rs_full, ms_overflow, ms_underflow, rs_overflow, rs_underflow, stack_fault} !==
                {m_md == 0, m_rd == 0, m_md == MSD, m_rd == RSD, m_mo, m_mu, m_ro, m_ru, m_mo | m_mu | m_ro | m_ru}) begin
                errors++;
                $display("FAIL rand_flags[%0d] got %b expected %b", n,
                         {ms_empty, rs_empty, ms_full, rs_full, ms_overflow, ms_underflow, rs_overflow, rs_underflow, stack_fault},
                         {m_md == 0, m_rd == 0, m_md == MSD, m_rd == RSD, m_mo, m_mu, m_ro, m_ru, m_mo | m_mu | m_ro | m_ru});
            end
`ifdef STACK_HWM_EN
            checks++;
            if ({ms_hwm, rs_hwm} !== {16'(m_mh), 16'(m_rh)}) begin
                errors++;
                $display("FAIL rand_hwm[%0d] ms=%0d rs=%0d expected %0d %0d", n, ms_hwm, rs_hwm, m_mh, m_rh);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_overflow();
        test_simultaneous();
`ifdef STACK_HWM_EN
        test_hwm();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- Holds the main stack pointer (MSP) and return stack pointer (RSP) for the stack CPU.
- Sits directly downstream of the control FSM and consumes its per-stack pop, write and register-reset strobes.
- Drives the stack addresses used by the memory-address muxes: top-of-stack and second-of-stack for each stack.
- Tracks depth per stack, guards against overflow and underflow, and raises sticky fault flags.

Parameters:
- MS_BASE, 16'h7FFE, MSP value when the main stack is empty (stack grows downward).
- RS_BASE, 16'h6FFE, RSP value when the return stack is empty.
- STEP, 2, byte stride per 16-bit stack entry.
- MS_DEPTH, 512, maximum main-stack entries.
- RS_DEPTH, 256, maximum return-stack entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MSPop  in  1  main-stack direction (1 = pop, 0 = push); qualified by MSPWrite.
- MSPWrite  in  1  main-stack pointer update enable.
- MSPRegReset  in  1  synchronous return of MSP to MS_BASE.
- RSPop  in  1  return-stack direction (1 = pop, 0 = push); qualified by RSPWrite.
- RSPWrite  in  1  return-stack pointer update enable.
- RSPRegReset  in  1  synchronous return of RSP to RS_BASE.
- msp  out  16  main-stack top-of-stack address.
- msp_second  out  16  msp + STEP, the second-of-stack address.
- rsp  out  16  return-stack top-of-stack address.
- ms_depth  out  16  main-stack entry count.
- rs_depth  out  16  return-stack entry count.
- ms_empty, rs_empty  out  1  each  depth == 0.
- ms_full, rs_full  out  1  each  depth == MS_DEPTH / RS_DEPTH respectively.
- ms_overflow, ms_underflow, rs_overflow, rs_underflow  out  1  each  sticky fault flags.
- stack_fault  out  1  OR of the four sticky fault flags.

Behaviour:
- Async rst:
  - msp = MS_BASE, rsp = RS_BASE.
  - Both depths 0.
  - All fault flags 0.
  - If STACK_HWM_EN is defined, both high-water marks 0.
- Each stack is an independent, identical channel; both may update in the same cycle.
- Per channel, evaluated at posedge clk in priority order:
  1. RegReset=1: pointer = BASE, depth = 0, the channel's overflow and underflow flags cleared. The Write strobe is ignored that cycle.
  2. Write=1 and Pop=1:
     - depth > 0: pointer += STEP, depth -= 1.
     - depth == 0: pointer and depth hold; underflow flag set.
  3. Write=1 and Pop=0:
     - depth < DEPTH: pointer -= STEP, depth += 1.
     - depth == DEPTH: pointer and depth hold; overflow flag set.
  4. Write=0: hold. Pop is don't-care.
- Latency: the new pointer is visible one cycle after the strobe edge. Control therefore issues a pointer update one state ahead of the memory access that uses it.
- Combinational outputs (no extra latency): msp_second, empty, full, stack_fault.
- Arithmetic: 16-bit modulo. BASE and DEPTH are chosen so no wrap occurs within range; the implementation does not check this.
- Flags are sticky: cleared only by rst or the channel's RegReset. A fault never corrupts the pointer.
- Pop and push strobes are level-sampled each edge. Write held for N cycles gives N updates.
- rst asserted mid-operation overrides everything immediately, regardless of clk.

Optional Feature:
- Macro: STACK_HWM_EN.
- Defined:
  - Adds ms_hwm and rs_hwm outputs, 16 bits each.
  - Each holds the maximum depth reached since rst or the channel's RegReset.
  - Updated the same edge as depth: hwm = max(hwm, new depth).
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: pulse rst between clock edges -> msp=16'h7FFE, rsp=16'h6FFE, depths 0, ms_empty=rs_empty=1, stack_fault=0, with no clk edge required.
- Push/pop main stack: 3 cycles MSPWrite=1/MSPop=0 -> msp=16'h7FF8, ms_depth=3, msp_second=16'h7FFA. Then 1 cycle MSPop=1 -> msp=16'h7FFA, ms_depth=2.
- Underflow: from reset, MSPWrite=1/MSPop=1 for one cycle -> msp stays 16'h7FFE, ms_underflow=1, stack_fault=1. Then MSPRegReset=1 for one cycle -> ms_underflow=0.
- Overflow: RS_DEPTH=4; 5 RSP pushes -> after the 4th, rsp=16'h6FF6 and rs_full=1. The 5th leaves rsp=16'h6FF6 and sets rs_overflow=1. MS flags stay 0.
- Simultaneous: same cycle MSP push, RSP pop (rs_depth=1), MSPRegReset=0 -> both update. Next cycle MSPWrite=1 with MSPRegReset=1 -> msp=16'h7FFE, depth 0 (reset wins).
- HWM (STACK_HWM_EN defined): push 5, pop 3 on main stack -> ms_hwm=5, ms_depth=2. After MSPRegReset -> ms_hwm=0.
